// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD command sequencer: state codes,
// power-on command tables and default timing, all in clk cycles.
package lcd_pkg;

  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_EN_DEF    = 12;
  localparam int unsigned T_HOLD_DEF  = 1;
  localparam int unsigned T_NIB_DEF   = 50;
  localparam int unsigned T_CMD_DEF   = 2000;
  localparam int unsigned T_CLR_DEF   = 82000;
  localparam int unsigned T_PWR_DEF   = 750000;
  localparam int unsigned T_INIT1_DEF = 205000;
  localparam int unsigned T_INIT2_DEF = 5000;

  // Sequencer states; SETUP/PULSE/HOLD of every nibble live in the writer (ST_XFER).
  localparam logic [2:0] ST_PWR_WAIT = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_XFER     = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_WAIT     = 3'd4;

  localparam logic [1:0] PH_OFF   = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_PULSE = 2'd2;
  localparam logic [1:0] PH_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    SRC_INIT,
    SRC_CFG,
    SRC_USER
  } src_e;

  // Wake-up nibbles 0x3,0x3,0x3 then 0x2 switches the panel into 4-bit mode.
  function automatic logic [3:0] init_nib(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Clear / home commands need the long settle time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Byte-write request channel into the LCD sequencer (valid/ready handshake).
interface lcd_cmd_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, req_rs, req_data, input req_ready);
  modport slave  (input req_valid, req_rs, req_data, output req_ready);
endinterface

// File: rtl/lcd_nibble_writer.sv
// One 4-bit LCD write: SETUP, an e pulse, HOLD. Timing runs on the
// sequencer's shared down-counter, which this block reloads via load/load_val.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_EN    = T_EN_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned CW      = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    start_nib,
  input  logic          start_rs,
  input  logic          cnt_last,
  output logic          load,
  output logic [CW-1:0] load_val,
  output logic          done,
  output logic          e,
  output logic [3:0]    nib,
  output logic          rs
);

  logic [1:0] phase;

  // NOTE: synchronous reset inside the clocked block, and <= for every
  // register so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_OFF;
      e     <= 1'b0;
      nib   <= 4'h0;
      rs    <= 1'b0;
    end else begin
      case (phase)
        PH_OFF: if (start) begin
          phase <= PH_SETUP;
          nib   <= start_nib;
          rs    <= start_rs;
        end
        PH_SETUP: if (cnt_last) begin
          phase <= PH_PULSE;
          e     <= 1'b1;
        end
        PH_PULSE: if (cnt_last) begin
          phase <= PH_HOLD;
          e     <= 1'b0;
        end
        default: if (cnt_last) phase <= PH_OFF;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned (which would infer a latch).
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (phase)
      PH_OFF:   if (start)    begin load = 1'b1; load_val = CW'(T_SETUP); end
      PH_SETUP: if (cnt_last) begin load = 1'b1; load_val = CW'(T_EN);    end
      PH_PULSE: if (cnt_last) begin load = 1'b1; load_val = CW'(T_HOLD);  end
      default: ;
    endcase
  end

  assign done = (phase == PH_HOLD) && cnt_last;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Character-LCD sequencer: power-on wait, 4-bit init, configuration bytes,
// then user byte writes as two nibbles followed by a command-dependent wait.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_EN    = T_EN_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_NIB   = T_NIB_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_CLR   = T_CLR_DEF,
  parameter int unsigned T_PWR   = T_PWR_DEF,
  parameter int unsigned T_INIT1 = T_INIT1_DEF,
  parameter int unsigned T_INIT2 = T_INIT2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  lcd_cmd_sequencer_if.slave  req,
  output logic                init_done,
  output logic                busy,
  output logic                sf_e,
  output logic                e,
  output logic                rs,
  output logic                rw,
  output logic                d,
  output logic                c,
  output logic                b,
  output logic                a
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_EN), max_u(T_HOLD, T_NIB)),
                                        max_u(max_u(T_CMD, T_CLR),
                                              max_u(T_PWR, max_u(T_INIT1, T_INIT2))));
  localparam int unsigned CW = $clog2(T_MAX + 1);

  logic [2:0]    state, state_n;
  src_e          src, src_n;
  logic [1:0]    idx, idx_n;
  logic          lower, lower_n;
  logic [7:0]    byte_q, byte_n;
  logic          rs_q, rs_n;
  logic [CW-1:0] cnt;
  logic          cnt_last;

  logic          start, start_rs;
  logic [3:0]    start_nib;
  logic          top_load;
  logic [CW-1:0] top_val;
  logic          wr_load, wr_done;
  logic [CW-1:0] wr_val;
  logic [3:0]    wr_nib;

  // A phase of N cycles loads N and ends on the cycle the counter reads 1.
  assign cnt_last = (cnt <= CW'(1));

  lcd_nibble_writer #(
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_HOLD  (T_HOLD),
    .CW      (CW)
  ) u_writer (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_nib (start_nib),
    .start_rs  (start_rs),
    .cnt_last  (cnt_last),
    .load      (wr_load),
    .load_val  (wr_val),
    .done      (wr_done),
    .e         (e),
    .nib       (wr_nib),
    .rs        (rs)
  );

  always_comb begin
    state_n   = state;
    src_n     = src;
    idx_n     = idx;
    lower_n   = lower;
    byte_n    = byte_q;
    rs_n      = rs_q;
    start     = 1'b0;
    start_nib = 4'h0;
    start_rs  = 1'b0;
    top_load  = 1'b0;
    top_val   = '0;
    case (state)
      ST_PWR_WAIT: if (cnt_last) begin
        state_n   = ST_XFER;
        src_n     = SRC_INIT;
        idx_n     = 2'd0;
        start     = 1'b1;
        start_nib = init_nib(2'd0);
      end
      ST_IDLE: if (req.req_valid) begin
        state_n   = ST_XFER;
        src_n     = SRC_USER;
        lower_n   = 1'b0;
        byte_n    = req.req_data;
        rs_n      = req.req_rs;
        start     = 1'b1;
        start_nib = req.req_data[7:4];
        start_rs  = req.req_rs;
      end
      ST_XFER: if (wr_done) begin
        top_load = 1'b1;
        if (src == SRC_INIT) begin
          state_n = ST_WAIT;
          top_val = (idx == 2'd0) ? CW'(T_INIT1) :
                    (idx == 2'd1) ? CW'(T_INIT2) : CW'(T_CMD);
        end else if (!lower) begin
          state_n = ST_GAP;
          lower_n = 1'b1;
          top_val = CW'(T_NIB);
        end else begin
          state_n = ST_WAIT;
          top_val = is_slow_cmd(rs_q, byte_q) ? CW'(T_CLR) : CW'(T_CMD);
        end
      end
      ST_GAP: if (cnt_last) begin
        state_n   = ST_XFER;
        start     = 1'b1;
        start_nib = byte_q[3:0];
        start_rs  = rs_q;
      end
      ST_WAIT: if (cnt_last) begin
        if (src == SRC_USER || (src == SRC_CFG && idx == 2'd3)) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_XFER;
          start   = 1'b1;
          lower_n = 1'b0;
          if (src == SRC_INIT && idx != 2'd3) begin
            idx_n     = idx + 2'd1;
            start_nib = init_nib(idx_n);
          end else begin
            src_n     = SRC_CFG;
            idx_n     = (src == SRC_INIT) ? 2'd0 : idx + 2'd1;
            byte_n    = cfg_byte(idx_n);
            rs_n      = 1'b0;
            start_nib = byte_n[7:4];
          end
        end
      end
      default: state_n = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PWR_WAIT;
      src       <= SRC_INIT;
      idx       <= 2'd0;
      lower     <= 1'b0;
      byte_q    <= 8'h00;
      rs_q      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      src       <= src_n;
      idx       <= idx_n;
      lower     <= lower_n;
      byte_q    <= byte_n;
      rs_q      <= rs_n;
      init_done <= init_done | (state_n == ST_IDLE);
    end
  end

  // The only timer: loaded by the writer for nibble phases, by the sequencer for waits.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= CW'(T_PWR);
    else if (wr_load)     cnt <= wr_val;
    else if (top_load)    cnt <= top_val;
    else if (cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign req.req_ready = (state == ST_IDLE) && init_done;
  assign busy          = (state != ST_IDLE);
  assign sf_e          = 1'b1;
  assign rw            = 1'b0;
  assign {d, c, b, a}  = wr_nib;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: a timeline model predicts every e pulse and
// every return to IDLE; a negedge monitor compares the observed bus against it.
module tb_lcd_cmd_sequencer;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 3;
  localparam int T_NIB   = 2;
  localparam int T_CMD   = 3;
  localparam int T_CLR   = 4;
  localparam int T_PWR   = 2;
  localparam int T_INIT1 = 4;
  localparam int T_INIT2 = 2;

  logic clk = 1'b0;
  logic rst;
  logic init_done, busy, sf_e, e, rs, rw, d, c, b, a;

  lcd_cmd_sequencer_if ifc ();

  lcd_cmd_sequencer #(
    .T_SETUP (T_SETUP), .T_EN (T_EN), .T_HOLD (T_HOLD), .T_NIB (T_NIB),
    .T_CMD (T_CMD), .T_CLR (T_CLR), .T_PWR (T_PWR),
    .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (ifc),
    .init_done (init_done),
    .busy      (busy),
    .sf_e      (sf_e),
    .e         (e),
    .rs        (rs),
    .rw        (rw),
    .d         (d),
    .c         (c),
    .b         (b),
    .a         (a)
  );

  always #5 clk = ~clk;

  // cyc read at a negedge equals the index of the rising edge just passed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;

  typedef struct {
    int         rise;
    logic [3:0] nib;
    logic       rs;
  } pulse_t;

  pulse_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Nibble whose data first appears at edge t; returns the edge its hold ends.
  function automatic int push_nib(input int t, input logic [3:0] nib, input logic r);
    pulse_t p;
    p.rise = t + T_SETUP;
    p.nib  = nib;
    p.rs   = r;
    exp_q.push_back(p);
    return p.rise + T_EN + T_HOLD;
  endfunction

  // Byte accepted at edge t; returns the edge at which IDLE is re-entered.
  function automatic int push_byte(input int t, input logic r, input logic [7:0] dat);
    int tt;
    tt = push_nib(t, dat[7:4], r) + T_NIB;
    tt = push_nib(tt, dat[3:0], r);
    return tt + ((!r && dat >= 8'h01 && dat <= 8'h03) ? T_CLR : T_CMD);
  endfunction

  function automatic int push_init(input int r_edge);
    int         t;
    int         waits [4];
    logic [3:0] nibs  [4];
    logic [7:0] cfg   [4];
    waits = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
    nibs  = '{4'h3, 4'h3, 4'h3, 4'h2};
    cfg   = '{8'h28, 8'h06, 8'h0C, 8'h01};
    t = r_edge + T_PWR;
    for (int i = 0; i < 4; i++) t = push_nib(t, nibs[i], 1'b0) + waits[i];
    for (int i = 0; i < 4; i++) t = push_byte(t, 1'b0, cfg[i]);
    return t;
  endfunction

  logic       prev_e = 1'b0;
  logic [3:0] nib_at_rise;
  logic       rs_at_rise;
  int         rise_at;
  pulse_t     pm;

  initial begin
    forever begin
      @(negedge clk);
      check("sf_e_high", sf_e, 1'b1);
      check("rw_low", rw, 1'b0);
      if (e === 1'b1 && prev_e !== 1'b1) begin
        rise_at     = cyc;
        nib_at_rise = {d, c, b, a};
        rs_at_rise  = rs;
      end else if (e === 1'b1) begin
        check("nib_stable", {d, c, b, a}, nib_at_rise);
        check("rs_stable", rs, rs_at_rise);
      end else if (prev_e === 1'b1 && rst !== 1'b1) begin
        n_pulse++;
        check("hold_nib", {d, c, b, a}, nib_at_rise);
        check("e_width", cyc - rise_at, T_EN);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          pm = exp_q.pop_front();
          check("rise_time", rise_at, pm.rise);
          check("nibble", nib_at_rise, pm.nib);
          check("rs_bit", rs_at_rise, pm.rs);
        end
      end
      prev_e = e;
    end
  end

  task automatic wait_ready(input int exp_edge, input string tag);
    int n = 0;
    while (ifc.req_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_seen"}, ifc.req_ready, 1'b1);
    check({tag, "_ready_time"}, cyc, exp_edge);
    check({tag, "_all_pulses"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_e"}, e, 1'b0);
    check({tag, "_rs"}, rs, 1'b0);
    check({tag, "_dcba"}, {d, c, b, a}, 4'h0);
    check({tag, "_ready"}, ifc.req_ready, 1'b0);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  // Call at the negedge where rst was just dropped.
  task automatic do_init(input string tag);
    int p0, t_rdy;
    p0    = n_pulse;
    t_rdy = push_init(cyc);
    wait_ready(t_rdy, tag);
    check({tag, "_pulse_count"}, n_pulse - p0, 12);
    check({tag, "_init_done"}, init_done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Call at a negedge with req_ready high; returns acceptance-to-IDLE cycles.
  task automatic run_byte(input logic r, input logic [7:0] dat, input bit junk, output int gap);
    int a_edge, t_rdy, n;
    ifc.req_valid = 1'b1;
    ifc.req_rs    = r;
    ifc.req_data  = dat;
    a_edge = cyc + 1;
    t_rdy  = push_byte(a_edge, r, dat);
    @(negedge clk);
    check("ready_drop", ifc.req_ready, 1'b0);
    check("busy_set", busy, 1'b1);
    n = 0;
    while (ifc.req_ready !== 1'b1 && n < 400) begin
      if (junk) begin
        ifc.req_rs   = 1'($urandom);
        ifc.req_data = 8'($urandom);
      end else begin
        ifc.req_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    ifc.req_valid = 1'b0;
    wait_ready(t_rdy, "xfer");
    gap = cyc - a_edge;
  endtask

  task automatic idle(input int n);
    ifc.req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", ifc.req_ready, 1'b1);
      check("idle_busy", busy, 1'b0);
    end
  endtask

  task automatic random_traffic(input int count);
    logic       r;
    logic [7:0] dat;
    bit         junk;
    int         g;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r   = 1'($urandom_range(0, 1));
        dat = 8'($urandom_range(1, 3));
      end else begin
        r   = 1'($urandom);
        dat = 8'($urandom);
      end
      junk = 1'($urandom);
      run_byte(r, dat, junk, g);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int g, g1, g2, n;

  initial begin
    rst           = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_rs    = 1'b0;
    ifc.req_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    do_init("init");
    idle(3);

    run_byte(1'b1, 8'h41, 1'b0, g);
    check("char_0x41_gap", g, 2 * (T_SETUP + T_EN + T_HOLD) + T_NIB + T_CMD);

    run_byte(1'b0, 8'h01, 1'b0, g1);
    idle(1);
    run_byte(1'b0, 8'h80, 1'b0, g2);
    check("clr_minus_cmd_gap", g1 - g2, T_CLR - T_CMD);

    run_byte(1'b0, 8'h02, 1'b1, g);
    run_byte(1'b1, 8'h7E, 1'b1, g);
    idle(2);

    random_traffic(24);

    ifc.req_valid = 1'b1;
    ifc.req_rs    = 1'b1;
    ifc.req_data  = 8'h5A;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    n = 0;
    while (e !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("e_high_before_rst", e, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_init("reinit");

    run_byte(1'b1, 8'h33, 1'b0, g);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, meaning clk cycles of data/rs valid before e rises.
REQ-002 SHALL have parameter T_EN, default 12, meaning clk cycles e is held high per nibble.
REQ-003 SHALL have parameter T_HOLD, default 1, meaning clk cycles data held after e falls.
REQ-004 SHALL have parameter T_NIB, default 50, meaning gap cycles between the upper and lower nibble.
REQ-005 SHALL have parameter T_CMD, default 2000, meaning wait cycles after a normal byte.
REQ-006 SHALL have parameter T_CLR, default 82000, meaning wait cycles after command 0x01, 0x02 or 0x03.
REQ-007 SHALL have parameters T_PWR 750000, T_INIT1 205000 and T_INIT2 5000, meaning power-on wait, wait after first 0x3 nibble, and wait after second 0x3 nibble.
REQ-008 SHALL have port: clk  in  1  single clock; all logic on its rising edge.
REQ-009 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-010 SHALL have port: req_valid  in  1  byte write request.
REQ-011 SHALL have port: req_ready  out  1  sequencer accepts a request this cycle.
REQ-012 SHALL have port: req_rs  in  1  0 = command, 1 = character data.
REQ-013 SHALL have port: req_data  in  8  byte to write.
REQ-014 SHALL have ports init_done (out, 1, power-on and configuration complete) and busy (out, 1, a transfer or wait is in progress).
REQ-015 SHALL have ports sf_e, e, rs, rw (out, 1 each) as the LCD/flash control pins, and d, c, b, a (out, 1 each) as LCD data bits 7..4, d = MSB.

Function
REQ-016 SHALL hold sf_e=1 and rw=0 at all times, including during reset.
REQ-017 SHALL sequence states PWR_WAIT -> INIT (nibbles 0x3,0x3,0x3,0x2) -> CFG (bytes 0x28,0x06,0x0C,0x01) -> IDLE -> SETUP -> PULSE -> HOLD -> GAP -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE.
REQ-018 SHALL wait after the INIT nibbles as follows: T_INIT1 after nibble 1, T_INIT2 after nibble 2, T_CMD after nibbles 3 and 4; INIT nibbles use rs=0 and a single e pulse each.
REQ-019 SHALL assert req_ready only in IDLE with init_done=1; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-020 SHALL latch req_rs and req_data on acceptance, deassert req_ready from the next cycle, and ignore input changes until IDLE is re-entered.
REQ-021 SHALL drive the upper nibble and rs in the cycle after acceptance, raise e exactly T_SETUP cycles later, keep e high exactly T_EN cycles, then hold the data T_HOLD cycles.
REQ-022 SHALL insert T_NIB cycles between the upper-nibble hold and the lower-nibble setup.
REQ-023 SHALL select the post-byte wait as T_CLR when rs=0 and data is 0x01, 0x02 or 0x03, and T_CMD otherwise.
REQ-024 SHALL return to IDLE with req_ready=1 in the cycle after the WAIT count expires; back-to-back requests are therefore never overlapped.
REQ-025 SHALL set busy=1 in every state except IDLE and set init_done=1 from the first IDLE entry onward.
REQ-026 SHALL drive e=0 outside PULSE and d/c/b/a to the latched nibble from SETUP through HOLD; in other states these outputs hold their last value.
REQ-027 SHALL use a single down-counter whose width is at least clog2(max parameter + 1), with 20 bits for the defaults; all waits are exact with no off-by-one.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter PWR_WAIT loaded with T_PWR and set e=0, rs=0, d=c=b=a=0, req_ready=0, init_done=0, busy=1.
REQ-029 SHALL, on reset mid-transfer or mid-init, abandon the transfer without completing the nibble, take e low on that same edge, and rerun the full init sequence.

Structure
REQ-030 SHALL place the state enumeration, the INIT/CFG command constants and the default timing constants in the shared package lcd_pkg.
REQ-031 SHALL implement the nibble write (SETUP/PULSE/HOLD timing) as one sub-module, lcd_nibble_writer, reused by the INIT, CFG and user paths.

Verification
REQ-032 SHALL cover: with all T_* set to 2-4, release rst -> e pulses exactly 4+8 times (4 INIT nibbles + 4 CFG bytes x2), CFG nibbles 2,8,0,6,0,C,0,1, then init_done=1 and req_ready=1.
REQ-033 SHALL cover: after init, req_rs=1 and req_data=0x41 -> rs=1, nibble 0x4 then 0x1, e high exactly T_EN cycles each, req_ready low until WAIT of T_CMD ends.
REQ-034 SHALL cover: command 0x01 versus 0x80 -> the IDLE return gap differs by exactly T_CLR-T_CMD cycles.
REQ-035 SHALL cover: req_valid held high with changing req_data during a transfer -> only the accepted byte appears on the bus, and the next byte is accepted only on re-entry to IDLE.
REQ-036 SHALL cover: rst pulsed while e=1 -> e=0 on the next edge, init_done=0, and the full init sequence repeats.
REQ-037 SHALL cover: throughout all scenarios sf_e=1 and rw=0, with d/c/b/a stable whenever e=1.
